// File: rtl/traffic_ctrl_multi.sv
// Multi-approach signal controller: main road 0 is green by default, side roads 1..N-1
// are latched and served round-robin, and every side-road green returns to the main road.

module traffic_ctrl_lane #(
    parameter int IDX = 0
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       sense,
    input  logic       own,
    input  logic       green,
    input  logic       yellow,
    input  logic       enter,
    output logic       pend,
    output logic [1:0] light
);
    // The main road never latches a request; a road cannot request itself while green.
    always_ff @(posedge clock) begin
        if (clear)
            pend <= 1'b0;
        else if (enter)
            pend <= 1'b0;
        else if ((IDX != 0) && sense && !(green && own))
            pend <= 1'b1;
    end

    always_comb begin
        light = 2'd0;
        if (own) begin
            if (green)
                light = 2'd2;
            else if (yellow)
                light = 2'd1;
        end
    end
endmodule

module traffic_ctrl_multi #(
    parameter int N_ROADS   = 4,
    parameter int Y2R_DELAY = 3,
    parameter int R2G_DELAY = 2,
    parameter int MIN_GREEN = 8,
    parameter int MAX_GREEN = 20,
    parameter int CNT_W     = 8
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [N_ROADS-1:0]     x,
    output logic [2*N_ROADS-1:0]   lights,
    output logic [2:0]             active,
    output logic [N_ROADS-1:0]     pending
);
    typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALL_RED} state_t;

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] Y2R_C = CNT_W'(Y2R_DELAY);
    localparam logic [CNT_W-1:0] R2G_C = CNT_W'(R2G_DELAY);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [2:0]         owner, owner_n;
    logic [2:0]         rr, rr_n;
    logic               enter;
    logic [N_ROADS-1:0] own, enter_vec;
    logic               side_req, found;
    int                 idx;

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= S_GREEN;
            cnt   <= ONE_C;
            owner <= 3'd0;
            rr    <= 3'd1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            owner <= owner_n;
            rr    <= rr_n;
        end
    end

    assign side_req = |(x & own);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        owner_n = owner;
        rr_n    = rr;
        enter   = 1'b0;
        found   = 1'b0;
        idx     = 0;
        case (state)
            S_GREEN: begin
                if ((owner == 3'd0) ? (cnt >= MIN_C && |pending)
                                    : ((cnt >= MIN_C && !side_req) || cnt == MAX_C)) begin
                    state_n = S_YELLOW;
                    cnt_n   = ONE_C;
                end else if (cnt != MAX_C) begin
                    cnt_n = cnt + ONE_C;
                end
            end
            S_YELLOW: begin
                if (cnt == Y2R_C) begin
                    state_n = S_ALL_RED;
                    cnt_n   = ONE_C;
                end else begin
                    cnt_n = cnt + ONE_C;
                end
            end
            default: begin
                if (cnt == R2G_C) begin
                    state_n = S_GREEN;
                    cnt_n   = ONE_C;
                    enter   = 1'b1;
                    owner_n = 3'd0;
                    // Only a main-road phase hands off to a side road; scan from rr.
                    if (owner == 3'd0) begin
                        for (int k = 0; k < N_ROADS - 1; k++) begin
                            idx = ((int'(rr) - 1 + k) % (N_ROADS - 1)) + 1;
                            if (!found && pending[idx]) begin
                                found   = 1'b1;
                                owner_n = 3'(idx);
                                rr_n    = (idx == N_ROADS - 1) ? 3'd1 : 3'(idx + 1);
                            end
                        end
                    end
                end else begin
                    cnt_n = cnt + ONE_C;
                end
            end
        endcase
    end

    for (genvar i = 0; i < N_ROADS; i++) begin : g_lane
        assign own[i]       = (owner == 3'(i));
        assign enter_vec[i] = enter && (owner_n == 3'(i));
        traffic_ctrl_lane #(.IDX(i)) u_lane (
            .clock  (clock),
            .clear  (clear),
            .sense  (x[i]),
            .own    (own[i]),
            .green  (state == S_GREEN),
            .yellow (state == S_YELLOW),
            .enter  (enter_vec[i]),
            .pend   (pending[i]),
            .light  (lights[2*i+1:2*i])
        );
    end

    assign active = owner;
endmodule
